gaussian_rdback: RTL

- Read-back end of the Gaussian filter result memory.
- The filter controller writes filtered pixels into bank 2 and raises `writefile` when the frame is complete. This block detects that event, then reads bank 2 in row-major order.
- Pixels are emitted as a valid/ready stream with frame/line markers, feeding the file-dump / display path.
- Border pixels that the filter never writes are replaced by a constant and are not read from memory.

---
 rtl/gaussian_pkg.sv | 19 +
 rtl/gaussian_rdback_if.sv | 32 +++
 rtl/gaussian_pix_fifo.sv | 55 +++++
 rtl/gaussian_rdback.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Constants shared by the Gaussian filter controller and its read-back path,
// plus the read-back FSM state encoding.
package gaussian_pkg;

    localparam int BITS    = 8;
    localparam int ADDRLEN = 21;
    localparam int ROW     = 720;
    localparam int COL     = 1280;
    localparam int WIDTH   = 7;
    localparam int MARGIN  = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rdback_state_t;

endpackage

// File: rtl/gaussian_rdback_if.sv
// Bank-2 read port, pixel stream and status of the read-back block.
// master = the read-back block, slave = memory / downstream side.
interface gaussian_rdback_if #(
    parameter int BITS    = gaussian_pkg::BITS,
    parameter int ADDRLEN = gaussian_pkg::ADDRLEN
);
    import gaussian_pkg::*;

    logic               start;
    logic [ADDRLEN-1:0] raddr;
    logic               ren;
    logic [BITS-1:0]    rdata;
    logic [BITS-1:0]    pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_sof;
    logic               pix_eol;
    logic               pix_eof;
    logic               busy;
    logic               done;

    modport master (
        input  start, rdata, pix_ready,
        output raddr, ren, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy, done
    );

    modport slave (
        output start, rdata, pix_ready,
        input  raddr, ren, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy, done
    );

endinterface

// File: rtl/gaussian_pix_fifo.sv
// Two-entry output FIFO holding {pixel, sof, eol, eof}; the head entry drives
// the stream outputs directly.
module gaussian_pix_fifo #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_headData,
    output logic [1:0]        o_occ
);
    import gaussian_pkg::*;

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (i_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The upstream credit rule must make these impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && !i_pop && r_occ == 2'd2));
            assert (!(i_pop && r_occ == 2'd0));
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_occ      = r_occ;

endmodule

// File: rtl/gaussian_rdback.sv
// Reads a finished frame out of bank 2 in row-major order and streams it with
// frame/line markers; border pixels are synthesised instead of read.
module gaussian_rdback #(
    parameter int BITS    = gaussian_pkg::BITS,
    parameter int ADDRLEN = gaussian_pkg::ADDRLEN,
    parameter int ROW     = gaussian_pkg::ROW,
    parameter int COL     = gaussian_pkg::COL,
    parameter int MARGIN  = gaussian_pkg::MARGIN,
    parameter logic [BITS-1:0] BORDER_VAL = '0
) (
    input logic clk,
    input logic rst,
    gaussian_rdback_if.master io_bus
);
    import gaussian_pkg::*;

    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);
    localparam int TW = BITS + 3;

    rdback_state_t      r_state;
    rdback_state_t      w_stateNext;
    logic               r_startPrev;
    logic               r_armed;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      r_col;
    logic [ADDRLEN-1:0] r_idx;
    logic               r_tagValid;
    logic               r_tagBorder;
    logic               r_tagSof;
    logic               r_tagEol;
    logic               r_tagEof;
    logic [1:0]         w_occ;
    logic [TW-1:0]      w_pushData;
    logic [TW-1:0]      w_headData;
    logic               w_valid;
    logic               w_pop;
    logic               w_issue;
    logic               w_startEdge;
    logic               w_interior;
    logic               w_lastCol;
    logic               w_lastPix;

    // r_armed masks the first cycle after reset so a start held high
    // through reset is not mistaken for a rising edge.
    assign w_startEdge = io_bus.start && !r_startPrev && r_armed;
    assign w_lastCol   = (r_col == CW'(COL - 1));
    assign w_lastPix   = w_lastCol && (r_row == RW'(ROW - 1));
    assign w_interior  = (r_row >= RW'(MARGIN)) && (r_row <= RW'(ROW - 1 - MARGIN)) &&
                         (r_col >= CW'(MARGIN)) && (r_col <= CW'(COL - 1 - MARGIN));
    assign w_valid     = (w_occ != 2'd0);
    assign w_pop       = w_valid && io_bus.pix_ready;
    assign w_issue     = (r_state == ST_RUN) &&
                         (({1'b0, w_occ} + {2'b00, r_tagValid}) < (3'd2 + {2'b00, w_pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_startPrev <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_startPrev <= io_bus.start;
            r_armed     <= 1'b1;
        end
    end

    // DRAIN may leave in the same cycle the final beat is taken, so done
    // follows the last beat by exactly one cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (w_startEdge) w_stateNext = ST_RUN;
            ST_RUN:   if (w_issue && w_lastPix) w_stateNext = ST_DRAIN;
            ST_DRAIN: if (!r_tagValid && (w_occ == 2'd0 || (w_occ == 2'd1 && w_pop)))
                          w_stateNext = ST_DONE;
            ST_DONE:  w_stateNext = ST_IDLE;
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    // r_idx tracks COL*r + c incrementally; everything holds after the last
    // issue and clears on the way back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (r_state == ST_DONE) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (w_issue && !w_lastPix) begin
            r_idx <= r_idx + ADDRLEN'(1);
            if (w_lastCol) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tagValid  <= 1'b0;
            r_tagBorder <= 1'b0;
            r_tagSof    <= 1'b0;
            r_tagEol    <= 1'b0;
            r_tagEof    <= 1'b0;
        end else begin
            r_tagValid <= w_issue;
            if (w_issue) begin
                r_tagBorder <= !w_interior;
                r_tagSof    <= (r_idx == '0);
                r_tagEol    <= w_lastCol;
                r_tagEof    <= w_lastPix;
            end
        end
    end

    assign w_pushData = {(r_tagBorder ? BORDER_VAL : io_bus.rdata), r_tagSof, r_tagEol, r_tagEof};

    gaussian_pix_fifo #(
        .DATA_W (TW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_tagValid),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_headData (w_headData),
        .o_occ      (w_occ)
    );

    assign io_bus.ren       = w_issue && w_interior;
    assign io_bus.raddr     = r_idx;
    assign io_bus.pix_valid = w_valid;
    assign io_bus.pix_data  = w_headData[TW-1:3];
    assign io_bus.pix_sof   = w_valid && w_headData[2];
    assign io_bus.pix_eol   = w_valid && w_headData[1];
    assign io_bus.pix_eof   = w_valid && w_headData[0];
    assign io_bus.busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign io_bus.done      = (r_state == ST_DONE);

endmodule
